// File: rtl/toll_payment_if.sv
// Handshake and status bundle between the toll payment unit and the
// fare logic / booth display / coin hardware.
interface toll_payment_if;
    logic        start;
    logic [7:0]  due_bcd;
    logic        coin_valid;
    logic [1:0]  coin_sel;
    logic        cancel;
    logic        busy;
    logic [11:0] paid_bcd;
    logic [7:0]  remain_bcd;
    logic [7:0]  change_bcd;
    logic        disp_valid;
    logic [1:0]  disp_coin;
    logic        done;
    logic        refunded;
    logic        err;

    modport master (
        output start, due_bcd, coin_valid, coin_sel, cancel,
        input  busy, paid_bcd, remain_bcd, change_bcd, disp_valid, disp_coin,
               done, refunded, err
    );

    modport slave (
        input  start, due_bcd, coin_valid, coin_sel, cancel,
        output busy, paid_bcd, remain_bcd, change_bcd, disp_valid, disp_coin,
               done, refunded, err
    );
endinterface

// File: rtl/toll_payment.sv
// Toll payment unit: latches the fare, counts inserted coins, then pays
// back change (or a full refund on cancel) one coin at a time using greedy
// denomination choice, with DISP_GAP idle cycles after every coin.
module toll_payment #(
    parameter int DISP_GAP = 4
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    toll_payment_if.slave bus
);

    localparam int GAP_W = (DISP_GAP > 1) ? $clog2(DISP_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DISP_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_SETTLE   = 3'd2,
        S_DISPENSE = 3'd3,
        S_GAP      = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    // Coin code to value: 0=1, 1=5, 2=10, 3=25.
    function automatic logic [6:0] coin_value(input logic [1:0] code);
        logic [6:0] val;
        case (code)
            2'd0:    val = 7'd1;
            2'd1:    val = 7'd5;
            2'd2:    val = 7'd10;
            2'd3:    val = 7'd25;
            default: val = 7'd1;
        endcase
        return val;
    endfunction

    // Largest denomination not exceeding the amount still owed back.
    function automatic logic [1:0] greedy_code(input logic [6:0] amt);
        logic [1:0] code;
        if (amt >= 7'd25) begin
            code = 2'd3;
        end else if (amt >= 7'd10) begin
            code = 2'd2;
        end else if (amt >= 7'd5) begin
            code = 2'd1;
        end else begin
            code = 2'd0;
        end
        return code;
    endfunction

    // Shift-and-add-3 binary to three BCD digits (input never exceeds 127).
    function automatic logic [11:0] bin_to_bcd3(input logic [6:0] v);
        logic [11:0] bcd;
        logic [6:0]  sh;
        bcd = 12'd0;
        sh  = v;
        for (int i = 0; i < 7; i++) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], sh[6]};
            sh  = {sh[5:0], 1'b0};
        end
        return bcd;
    endfunction

    // Two-digit variant for values known to stay below 100.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
        logic [7:0] bcd;
        logic [6:0] sh;
        bcd = 8'd0;
        sh  = v;
        for (int i = 0; i < 7; i++) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[6:0], sh[6]};
            sh  = {sh[5:0], 1'b0};
        end
        return bcd;
    endfunction

    state_t           r_state;
    logic [6:0]       r_due;
    logic [6:0]       r_paid;
    logic [6:0]       r_change;
    logic             r_refund;
    logic             r_err;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_busy;
    logic             r_disp_valid;
    logic [1:0]       r_disp_coin;
    logic             r_done;
    logic             r_refunded;

    state_t           w_next_state;
    logic [6:0]       w_due_next;
    logic [6:0]       w_paid_next;
    logic [6:0]       w_change_next;
    logic             w_refund_next;
    logic             w_err_next;
    logic [GAP_W-1:0] w_gap_next;

    logic [6:0]       w_due_bin;
    logic             w_due_ok;
    logic [6:0]       w_paid_sum;
    logic [6:0]       w_remain_bin;

    assign w_due_bin  = ({3'b000, bus.due_bcd[7:4]} * 7'd10) + {3'b000, bus.due_bcd[3:0]};
    assign w_due_ok   = (bus.due_bcd[7:4] <= 4'd9) && (bus.due_bcd[3:0] <= 4'd9)
                        && (bus.due_bcd != 8'h00);
    assign w_paid_sum = r_paid + coin_value(bus.coin_sel);
    assign w_remain_bin = (r_due > r_paid) ? (r_due - r_paid) : 7'd0;

    // Next-state and next-datapath decode for the payment sequence.
    always_comb begin
        w_next_state  = r_state;
        w_due_next    = r_due;
        w_paid_next   = r_paid;
        w_change_next = r_change;
        w_refund_next = r_refund;
        w_err_next    = r_err;
        w_gap_next    = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_due_ok) begin
                        w_due_next    = w_due_bin;
                        w_paid_next   = 7'd0;
                        w_change_next = 7'd0;
                        w_refund_next = 1'b0;
                        w_err_next    = 1'b0;
                        w_next_state  = S_COLLECT;
                    end else begin
                        w_err_next    = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_COLLECT: begin
                // Cancel wins over a coin arriving in the same cycle.
                if (bus.cancel) begin
                    w_change_next = r_paid;
                    w_refund_next = 1'b1;
                    w_next_state  = S_SETTLE;
                end else if (bus.coin_valid) begin
                    w_paid_next = w_paid_sum;
                    if (w_paid_sum >= r_due) begin
                        w_change_next = w_paid_sum - r_due;
                        w_next_state  = S_SETTLE;
                    end else begin
                        w_next_state  = S_COLLECT;
                    end
                end else begin
                    w_next_state = S_COLLECT;
                end
            end
            S_SETTLE: begin
                if (r_change != 7'd0) begin
                    w_next_state = S_DISPENSE;
                end else begin
                    w_next_state = S_FINISH;
                end
            end
            S_DISPENSE: begin
                w_change_next = r_change - coin_value(greedy_code(r_change));
                w_gap_next    = GAP_LOAD;
                w_next_state  = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_ZERO) begin
                    if (r_change != 7'd0) begin
                        w_next_state = S_DISPENSE;
                    end else begin
                        w_next_state = S_FINISH;
                    end
                end else begin
                    w_gap_next = r_gap_cnt - GAP_ONE;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fare, paid, change, refund flag, error level and gap counter.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_due     <= 7'd0;
            r_paid    <= 7'd0;
            r_change  <= 7'd0;
            r_refund  <= 1'b0;
            r_err     <= 1'b0;
            r_gap_cnt <= GAP_ZERO;
        end else begin
            r_due     <= w_due_next;
            r_paid    <= w_paid_next;
            r_change  <= w_change_next;
            r_refund  <= w_refund_next;
            r_err     <= w_err_next;
            r_gap_cnt <= w_gap_next;
        end
    end

    // Control outputs registered from the upcoming state so they line up with it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_busy       <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_coin  <= 2'd0;
            r_done       <= 1'b0;
            r_refunded   <= 1'b0;
        end else begin
            r_busy       <= (w_next_state != S_IDLE);
            r_disp_valid <= (w_next_state == S_DISPENSE);
            r_disp_coin  <= (w_next_state == S_DISPENSE) ? greedy_code(w_change_next) : 2'd0;
            r_done       <= (w_next_state == S_FINISH) && !w_refund_next;
            r_refunded   <= (w_next_state == S_FINISH) && w_refund_next;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.paid_bcd   = bin_to_bcd3(r_paid);
    assign bus.remain_bcd = bin_to_bcd2(w_remain_bin);
    assign bus.change_bcd = bin_to_bcd2(r_change);
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_coin  = r_disp_coin;
    assign bus.done       = r_done;
    assign bus.refunded   = r_refunded;
    assign bus.err        = r_err;

endmodule

// File: doc/toll_payment.md
Name: toll_payment

Overview:
- Customer-side payment unit for the toll booth.
- Takes the toll due for the classified vehicle (2-digit BCD), accepts coin insertions, and tracks the amount paid and the amount remaining.
- Returns change, or a full refund on cancel, as a paced sequence of coin-dispense pulses using greedy denomination selection.
- Sits between the vehicle classifier/fare logic and the booth display/GPIO coin hardware; its `done` pulse is the event that commits the fare to the accumulated total.

Parameters:
- DISP_GAP, default 4: idle cycles after each dispense pulse. Board builds override it to about 25_000_000 for a visible ~0.5 s spacing.

Ports:
- `CLOCK_50`, in, 1: system clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; latch `due_bcd` and begin a transaction.
- `due_bcd`, in, 8: toll due; [7:4] tens, [3:0] units.
- `coin_valid`, in, 1: one-cycle pulse; one coin inserted.
- `coin_sel`, in, 2: denomination, 0=1, 1=5, 2=10, 3=25.
- `cancel`, in, 1: one-cycle pulse; abort and refund.
- `busy`, out, 1: transaction in progress (any state except IDLE).
- `paid_bcd`, out, 12: amount paid, 3 BCD digits.
- `remain_bcd`, out, 8: due minus paid, 2 BCD digits; 0 once paid ≥ due.
- `change_bcd`, out, 8: change still to be dispensed, 2 BCD digits.
- `disp_valid`, out, 1: one-cycle pulse; dispense one coin of `disp_coin`.
- `disp_coin`, out, 2: denomination being dispensed, same encoding as `coin_sel`.
- `done`, out, 1: one-cycle pulse; fare paid and change fully returned.
- `refunded`, out, 1: one-cycle pulse; cancel refund complete.
- `err`, out, 1: level; last `start` was rejected. Cleared by the next accepted `start`.

Behaviour:
- **Reset:**
  - State goes to IDLE.
  - All outputs are 0, including every BCD value and `err`.
  - A reset mid-transaction abandons it; no `done` or `refunded` pulse is produced.
- **Internal arithmetic:** `paid` and `due` are held in binary (7 bits; maximum paid is 98+25=123). The BCD outputs are combinational conversions of registered values.
- **States:** IDLE, COLLECT, SETTLE, DISPENSE, GAP, FINISH.
- **IDLE:**
  - `coin_valid` and `cancel` are ignored.
  - On `start`, `due_bcd` is rejected when either digit is >9 or its value is 0. Rejection sets `err`=1 and the state stays IDLE.
  - Otherwise the block latches `due`, clears `paid` and change, sets `err`=0, and moves to COLLECT.
- **COLLECT:**
  - A coin at edge n adds its value to `paid`; the new `paid` is visible after edge n.
  - If the new `paid` ≥ `due`, change = `paid` − `due` and the next state is SETTLE.
  - `cancel` has priority over a coin in the same cycle; that coin is not counted.
  - On `cancel`, change = `paid`, a refund flag is set, and the next state is SETTLE.
  - `start` is ignored in every non-IDLE state.
- **SETTLE** (1 cycle): go to DISPENSE if change > 0, else FINISH.
- **DISPENSE** (1 cycle):
  - `disp_valid`=1 with `disp_coin` = largest denomination ≤ change (25, 10, 5, 1).
  - Change decrements by that value on the same edge.
  - Next state is GAP.
- **GAP:**
  - Lasts DISP_GAP cycles.
  - Then go to DISPENSE if change > 0, else FINISH.
  - Coins arriving during SETTLE, DISPENSE or GAP are ignored; they are mechanically rejected.
- **FINISH** (1 cycle):
  - Pulse `done`, or `refunded` if the refund flag is set; never both.
  - Next state is IDLE, with `busy`=0 from the following cycle.
  - `paid_bcd` is held until the next accepted `start`.
- **Exact-payment latency:** final coin at edge n gives SETTLE in cycle n+1, `done` in cycle n+2, and `busy`=0 in cycle n+3.
- **Cancel with `paid`=0:** SETTLE → FINISH, producing `refunded` with no dispense.
- **`disp_valid` spacing:** exactly DISP_GAP+1 cycles between rising pulses.

Test Plan:
1. `due_bcd`=0x25, coins 10,10,10 → `paid_bcd`=0x030, `remain_bcd` 0x15→0x05→0x00. One `disp_valid` with `disp_coin`=1 (value 5), then `done`; `refunded` stays 0.
2. `due_bcd`=0x10, single coin 10 → no `disp_valid`; `done` exactly 2 cycles after the coin edge; `busy` falls the cycle after.
3. `due_bcd`=0x01, coin 25 → `change_bcd`=0x24. Dispense sequence 10,10,1,1,1,1 (six pulses, DISP_GAP+1 apart), then `done`.
4. `due_bcd`=0x50, coins 25 and 1, then `cancel` asserted together with a coin 10 → coin ignored; refund 25 then 1; `refunded` pulse; no `done`.
5. `start` with `due_bcd`=0x1A, then with 0x00 → `err`=1 and `busy`=0 each time. A valid `start` with 0x10 clears `err`.
6. Assert `reset_n` low during GAP of a refund → all outputs 0 immediately; no further `disp_valid`, `done` or `refunded`. A new `start` after release works normally.
